// File: rtl/data_bus_interface.sv
// Data-side bus interface of the 65C02 core: captures read data into the
// input latches or instruction register, drives write data during phi2.
module data_bus_interface #(
    parameter logic [7:0] NOP_OPCODE = 8'hEA
) (
    input  logic       fclk,
    input  logic       resb,
    input  logic [1:0] q,
    input  logic       phi2,
    input  logic       be,
    input  logic       rwb,
    input  logic       rdy,
    input  logic [1:0] latch_ctrl,
    input  logic       ir_load,
    input  logic [7:0] data_in,
    input  logic [7:0] write_data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] input_data_latch_A,
    output logic [7:0] input_data_latch_B,
    output logic [7:0] ir_out,
    output logic       byte_valid,
    output logic       word_valid,
    output logic       phase_err
);

    typedef enum logic {W_IDLE, W_HIGH} word_state_t;

    word_state_t state, state_next;
    logic [1:0]  q_prev;
    logic        capture;
    logic        word_cmd;
    logic        load_a;
    logic        load_b;
    logic        load_ir;
    logic        word_done;

    always_comb begin
        capture  = (q == 2'd3) && phi2 && rwb && rdy;
        word_cmd = capture && !ir_load && (latch_ctrl == 2'b11);
    end

    always_ff @(posedge fclk) begin
        if (!resb) begin
            state <= W_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Any capture that is not the continuation of a word fetch drops back
    // to idle, which discards a pending low byte.
    always_comb begin
        state_next = state;
        if (capture) begin
            if (word_cmd && (state == W_IDLE)) begin
                state_next = W_HIGH;
            end else begin
                state_next = W_IDLE;
            end
        end
    end

    always_comb begin
        load_ir   = capture && ir_load;
        load_b    = capture && !ir_load &&
                    ((latch_ctrl == 2'b01) || ((latch_ctrl == 2'b11) && (state == W_IDLE)));
        load_a    = capture && !ir_load &&
                    ((latch_ctrl == 2'b10) || ((latch_ctrl == 2'b11) && (state == W_HIGH)));
        word_done = word_cmd && (state == W_HIGH);
    end

    always_ff @(posedge fclk) begin
        if (!resb) begin
            data_out           <= '0;
            data_oe            <= 1'b0;
            input_data_latch_A <= '0;
            input_data_latch_B <= '0;
            ir_out             <= NOP_OPCODE;
            byte_valid         <= 1'b0;
            word_valid         <= 1'b0;
            phase_err          <= 1'b0;
            q_prev             <= 2'd3;
        end else begin
            q_prev <= q;
            if (q != (q_prev + 2'd1)) begin
                phase_err <= 1'b1;
            end

            byte_valid <= capture;
            word_valid <= word_done;

            if (load_ir) begin
                ir_out <= data_in;
            end
            if (load_a) begin
                input_data_latch_A <= data_in;
            end
            if (load_b) begin
                input_data_latch_B <= data_in;
            end

            // be low overrides everything; data_out keeps its last value.
            if (!be) begin
                data_oe <= 1'b0;
            end else if ((q == 2'd1) && !rwb) begin
                data_out <= write_data_in;
                data_oe  <= 1'b1;
            end else if (q == 2'd3) begin
                data_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_interface.sv
// Directed and randomized bench for data_bus_interface, checked edge by edge
// against a behavioural model of the bus rules.
module tb_data_bus_interface;

    logic       fclk = 1'b0;
    logic       resb;
    logic [1:0] q;
    logic       phi2;
    logic       be;
    logic       rwb;
    logic       rdy;
    logic [1:0] latch_ctrl;
    logic       ir_load;
    logic [7:0] data_in;
    logic [7:0] write_data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] input_data_latch_A;
    logic [7:0] input_data_latch_B;
    logic [7:0] ir_out;
    logic       byte_valid;
    logic       word_valid;
    logic       phase_err;

    data_bus_interface #(.NOP_OPCODE(8'hEA)) dut (
        .fclk(fclk),
        .resb(resb),
        .q(q),
        .phi2(phi2),
        .be(be),
        .rwb(rwb),
        .rdy(rdy),
        .latch_ctrl(latch_ctrl),
        .ir_load(ir_load),
        .data_in(data_in),
        .write_data_in(write_data_in),
        .data_out(data_out),
        .data_oe(data_oe),
        .input_data_latch_A(input_data_latch_A),
        .input_data_latch_B(input_data_latch_B),
        .ir_out(ir_out),
        .byte_valid(byte_valid),
        .word_valid(word_valid),
        .phase_err(phase_err)
    );

    always #5 fclk = ~fclk;

    int n_total = 0;
    int n_pass  = 0;
    int bv_cnt  = 0;
    int wv_cnt  = 0;

    // Reference state
    logic [7:0] m_dout, m_a, m_b, m_ir;
    logic       m_oe, m_bv, m_wv, m_perr;
    int         m_qprev;
    bit         m_have_low;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit cap;
        if (!resb) begin
            m_dout = 8'h00; m_oe = 1'b0; m_a = 8'h00; m_b = 8'h00; m_ir = 8'hEA;
            m_bv = 1'b0; m_wv = 1'b0; m_perr = 1'b0; m_qprev = 3; m_have_low = 0;
        end else begin
            cap = (q == 2'd3) && phi2 && rwb && rdy;
            if (int'(q) != (m_qprev + 1) % 4) m_perr = 1'b1;
            m_qprev = int'(q);
            m_bv = cap;
            m_wv = 1'b0;
            if (cap) begin
                if (ir_load) begin
                    m_ir = data_in;
                    m_have_low = 0;
                end else if (latch_ctrl == 2'b11) begin
                    if (!m_have_low) begin
                        m_b = data_in;
                        m_have_low = 1;
                    end else begin
                        m_a = data_in;
                        m_wv = 1'b1;
                        m_have_low = 0;
                    end
                end else begin
                    if (latch_ctrl == 2'b01) m_b = data_in;
                    if (latch_ctrl == 2'b10) m_a = data_in;
                    m_have_low = 0;
                end
            end
            if (!be) m_oe = 1'b0;
            else if (q == 2'd1 && !rwb) begin
                m_dout = write_data_in;
                m_oe = 1'b1;
            end else if (q == 2'd3) m_oe = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("data_out",   data_out,           m_dout);
        chk("data_oe",    {7'b0, data_oe},    {7'b0, m_oe});
        chk("latch_A",    input_data_latch_A, m_a);
        chk("latch_B",    input_data_latch_B, m_b);
        chk("ir_out",     ir_out,             m_ir);
        chk("byte_valid", {7'b0, byte_valid}, {7'b0, m_bv});
        chk("word_valid", {7'b0, word_valid}, {7'b0, m_wv});
        chk("phase_err",  {7'b0, phase_err},  {7'b0, m_perr});
    endtask

    task automatic step();
        @(posedge fclk);
        model_edge();
        #1;
        check_all();
        if (byte_valid) bv_cnt++;
        if (word_valid) wv_cnt++;
    endtask

    task automatic drv(input logic [1:0] qq, input logic r, input logic rd,
                       input logic [1:0] lc, input logic il, input logic b,
                       input logic [7:0] d, input logic [7:0] wd, input logic rs);
        q = qq; phi2 = (qq >= 2'd2); rwb = r; rdy = rd; latch_ctrl = lc;
        ir_load = il; be = b; data_in = d; write_data_in = wd; resb = rs;
        step();
    endtask

    task automatic bus_cycle(input logic r, input logic rd, input logic [1:0] lc,
                             input logic il, input logic b, input logic [7:0] d,
                             input logic [7:0] wd);
        for (int i = 0; i < 4; i++) drv(2'(i), r, rd, lc, il, b, d, wd, 1'b1);
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        drv(2'd2, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0);
        drv(2'd3, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset
        do_reset();
        chk("rst_ir",   ir_out, 8'hEA);
        chk("rst_A",    input_data_latch_A, 8'h00);
        chk("rst_B",    input_data_latch_B, 8'h00);
        chk("rst_oe",   {7'b0, data_oe}, 8'h00);
        chk("rst_perr", {7'b0, phase_err}, 8'h00);

        // Word fetch
        bv_cnt = 0; wv_cnt = 0;
        bus_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h34, 8'h00);
        chk("word_B", input_data_latch_B, 8'h34);
        bus_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h12, 8'h00);
        chk("word_A", input_data_latch_A, 8'h12);
        idle_cycle();
        chk("word_bv_cnt", 8'(bv_cnt), 8'd2);
        chk("word_wv_cnt", 8'(wv_cnt), 8'd1);

        // rdy stall
        do_reset();
        bv_cnt = 0;
        bus_cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'hAA, 8'h00);
        bus_cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'hAA, 8'h00);
        chk("stall_B", input_data_latch_B, 8'h00);
        bus_cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'hBB, 8'h00);
        idle_cycle();
        chk("stall_B_done", input_data_latch_B, 8'hBB);
        chk("stall_bv_cnt", 8'(bv_cnt), 8'd1);

        // Write cycle, then one with be dropped at q=2
        drv(2'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1);
        chk("wr_oe_q1", {7'b0, data_oe}, 8'h00);
        drv(2'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1);
        chk("wr_oe_q2", {7'b0, data_oe}, 8'h01);
        chk("wr_dout",  data_out, 8'hC3);
        drv(2'd2, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1);
        chk("wr_oe_q3", {7'b0, data_oe}, 8'h01);
        drv(2'd3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b1);
        chk("wr_oe_q0", {7'b0, data_oe}, 8'h00);
        drv(2'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b1);
        drv(2'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b1);
        drv(2'd2, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b1);
        chk("wr_be_drop_oe",   {7'b0, data_oe}, 8'h00);
        chk("wr_be_drop_dout", data_out, 8'h3C);
        drv(2'd3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b1);

        // Aborted word fetch followed by an opcode fetch
        wv_cnt = 0;
        bus_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h01, 8'h00);
        bus_cycle(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 8'hA9, 8'h00);
        idle_cycle();
        chk("abort_ir", ir_out, 8'hA9);
        chk("abort_B",  input_data_latch_B, 8'h01);
        chk("abort_A",  input_data_latch_A, 8'h00);
        chk("abort_wv_cnt", 8'(wv_cnt), 8'd0);
        bus_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h56, 8'h00);
        chk("abort_idle_B", input_data_latch_B, 8'h56);
        bus_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 8'h78, 8'h00);
        chk("abort_idle_A", input_data_latch_A, 8'h78);

        // Phase error: q 0,1,3
        drv(2'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        drv(2'd1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        chk("perr_before", {7'b0, phase_err}, 8'h00);
        drv(2'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        chk("perr_set", {7'b0, phase_err}, 8'h01);
        idle_cycle();
        idle_cycle();
        chk("perr_sticky", {7'b0, phase_err}, 8'h01);
        do_reset();
        chk("perr_cleared", {7'b0, phase_err}, 8'h00);

        // Randomized traffic, occasional reset at a cycle boundary
        for (int c = 0; c < 300; c++) begin
            logic       rs_at_end;
            logic [1:0] lc;
            logic       il;
            rs_at_end = ($urandom_range(0, 19) == 0);
            lc = 2'($urandom_range(0, 3));
            il = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                drv(2'(i),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : lc,
                    il,
                    ($urandom_range(0, 7) != 0),
                    8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)),
                    !(rs_at_end && i == 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
